// File: rtl/cmp_seq_ctrl.sv
// Sequential magnitude compare of two multi-nibble operands through an external
// 4-bit comparator, MSB nibble first, with early exit, abort and sanity check.
module cmp_seq_ctrl #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [4*NIB-1:0] op_a,
  input  logic [4*NIB-1:0] op_b,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic [2:0]       cmp_q,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result,
  output logic             err
);

  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [2:0]    result_q, result_d;
  logic          err_q, err_d;

  // Present the current nibble pair to the external comparator only while comparing.
  always_comb begin
    cmp_a = 4'h0;
    cmp_b = 4'h0;
    if (state_q == ST_CMP) begin
      cmp_a = opa_q[{idx_q, 2'b00} +: 4];
      cmp_b = opb_q[{idx_q, 2'b00} +: 4];
    end else begin
      cmp_a = 4'h0;
      cmp_b = 4'h0;
    end
  end

  // Next-state and datapath update; abort outranks every comparator outcome.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d    = op_a;
          opb_d    = op_b;
          idx_d    = IDX_TOP;
          err_d    = 1'b0;
          result_d = 3'b000;
          state_d  = ST_CMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (abort) begin
          result_d = 3'b000;
          state_d  = ST_IDLE;
        end else begin
          case (cmp_q)
            3'b100, 3'b001: begin
              result_d = cmp_q;
              state_d  = ST_DONE;
            end
            3'b010: begin
              if (idx_q != {IW{1'b0}}) begin
                idx_d = idx_q - IW'(1);
              end else begin
                result_d = 3'b010;
                state_d  = ST_DONE;
              end
            end
            default: begin
              // Comparator produced an impossible code: flag it rather than guess.
              result_d = 3'b000;
              err_d    = 1'b1;
              state_d  = ST_DONE;
            end
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_TOP;
      opa_q    <= {W{1'b0}};
      opb_q    <= {W{1'b0}};
      result_q <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == ST_CMP) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule
